// File: rtl/ps2_paddle_keys.sv
`timescale 1ns/1ps
// ps2_paddle_keys: PS/2 set-2 receiver and make/break decoder driving eight paddle key levels
//   clock, reset_n (async, active-high) | ps2_clk, ps2_dat: raw pad inputs
//   p1_*: W/S/A/D held levels | p2_*: arrow-key held levels
//   byte_valid/rx_byte: good-byte pulse and last byte | frame_err: parity/stop/timeout pulse
module ps2_paddle_keys #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  // sized so the default 5000-cycle limit is reachable
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0] cs, ds;
  logic ch, fall, dat;
  state_t st;
  logic [2:0] bc;
  logic [7:0] sr;
  logic par;
  logic [TW-1:0] tc;
  logic to;
  logic ext, brk;
  logic [7:0] keys, hit;
  // synchronisers idle high; fall/dat are registered so the receiver sees the pin edge 3 cycles late
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) begin
      cs <= 2'b11;
      ds <= 2'b11;
      ch <= 1'b1;
      fall <= 1'b0;
      dat <= 1'b1;
    end else begin
      cs <= {cs[0], ps2_clk};
      ds <= {ds[0], ps2_dat};
      ch <= cs[1];
      fall <= ch & ~cs[1];
      dat <= ds[1];
    end
  assign to = st != IDLE && !fall && tc == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) begin
      st <= IDLE;
      bc <= '0;
      sr <= '0;
      par <= 1'b0;
      tc <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      rx_byte <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      tc <= (st == IDLE || fall) ? '0 : tc + TW'(1);
      if (to) begin
        st <= IDLE;
        frame_err <= 1'b1;
      end else if (fall)
        case (st)
          IDLE: if (!dat) begin
            st <= DATA;
            bc <= '0;
          end
          DATA: begin
            sr <= {dat, sr[7:1]};
            bc <= bc + 3'd1;
            if (bc == 3'd7) st <= PARITY;
          end
          PARITY: begin
            par <= dat;
            st <= STOP;
          end
          STOP: begin
            st <= IDLE;
            if (dat && ^{sr, par}) begin
              rx_byte <= sr;
              byte_valid <= 1'b1;
            end else frame_err <= 1'b1;
          end
        endcase
    end
  // key order: {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up}
  assign hit = {ext && rx_byte == 8'h74, ext && rx_byte == 8'h6B, ext && rx_byte == 8'h72, ext && rx_byte == 8'h75,
                !ext && rx_byte == 8'h23, !ext && rx_byte == 8'h1C, !ext && rx_byte == 8'h1B, !ext && rx_byte == 8'h1D};
  always_ff @(posedge clock or posedge reset_n)
    if (reset_n) begin
      ext <= 1'b0;
      brk <= 1'b0;
      keys <= '0;
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == 8'hE0) ext <= 1'b1;
      else if (rx_byte == 8'hF0) brk <= 1'b1;
      else begin
        keys <= (keys & ~hit) | (hit & {8{!brk}});
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  assign {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up} = keys;
endmodule

// File: tb/tb_ps2_paddle_keys.sv
`timescale 1ns/1ps
// tb_ps2_paddle_keys: directed PS/2 frames with hand-computed key/byte expectations
module tb_ps2_paddle_keys;
  logic clock = 1'b0, reset_n = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic p1_up, p1_down, p1_left, p1_right, p2_up, p2_down, p2_left, p2_right;
  logic byte_valid, frame_err;
  logic [7:0] rx_byte;
  logic [7:0] keys, keys_prev;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_edge = 0, bv_cyc = 0, fe_cyc = 0, key_cyc = 0;
  int bv_cnt = 0, fe_cnt = 0, overlap = 0, long_cnt = 0;
  logic bv_prev = 1'b0, fe_prev = 1'b0;
  int bv0, fe0;
  logic [10:0] f;
  ps2_paddle_keys #(.TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .frame_err(frame_err)
  );
  assign keys = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (byte_valid) begin bv_cnt++; bv_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (byte_valid && frame_err) overlap++;
    if ((byte_valid && bv_prev) || (frame_err && fe_prev)) long_cnt++;
    bv_prev = byte_valid;
    fe_prev = frame_err;
    if (keys !== keys_prev) key_cyc = cyc;
    keys_prev = keys;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
    return {1'b1, bad ? ^b : ~^b, b, 1'b0};
  endfunction
  task automatic ps2_bit(input logic v);
    @(negedge clock) ps2_dat = v;
    repeat (4) @(negedge clock);
    ps2_clk = 1'b0;
    last_edge = cyc;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clock);
  endtask
  task automatic send_range(input logic [10:0] fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(fr[i]);
  endtask
  task automatic send(input logic [7:0] b, input logic bad = 1'b0);
    send_range(frame(b, bad), 0, 10);
    repeat (10) @(negedge clock);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_keys", keys, 8'h00);
    check("reset_rx", rx_byte, 8'h00);
    check("reset_pulses", {byte_valid, frame_err}, 2'b00);
    bv0 = bv_cnt;
    send(8'h1D);
    check("w_bv_count", bv_cnt - bv0, 1);
    check("w_rx", rx_byte, 8'h1D);
    check("w_make", keys, 8'h01);
    check("bv_latency", bv_cyc - last_edge, 4);
    check("key_latency", key_cyc - last_edge, 5);
    send(8'hF0); send(8'h1D);
    check("w_break", keys, 8'h00);
    send(8'hE0); send(8'h75);
    check("up_make", keys, 8'h10);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_break", keys, 8'h00);
    send(8'h75);
    check("plain_75_rx", rx_byte, 8'h75);
    check("plain_75_keys", keys, 8'h00);
    send(8'hE0); send(8'h1D);
    check("ext_1d_unmapped", keys, 8'h00);
    send(8'h1D); send(8'h1B);
    check("w_s_held", keys, 8'h03);
    send(8'hF0); send(8'h1D);
    check("w_released_s_held", keys, 8'h02);
    send(8'hE0); send(8'h6B); send(8'h23);
    check("left_d_added", keys, 8'h4A);
    send(8'hF0); send(8'h1B); send(8'hE0); send(8'hF0); send(8'h6B); send(8'hF0); send(8'h23);
    check("all_released", keys, 8'h00);
    bv0 = bv_cnt; fe0 = fe_cnt;
    send(8'h1D, 1'b1);
    check("par_err_fe", fe_cnt - fe0, 1);
    check("par_err_no_bv", bv_cnt - bv0, 0);
    check("par_err_keys", keys, 8'h00);
    send(8'hF0); send(8'h1D, 1'b1); send(8'h1D);
    check("err_clears_brk", keys, 8'h01);
    send(8'hF0); send(8'h1D);
    check("w_released_again", keys, 8'h00);
    send(8'hE0);
    fe0 = fe_cnt;
    send_range(frame(8'h23, 1'b0), 0, 4);
    for (int t = 0; t < 300 && fe_cnt == fe0; t++) @(negedge clock);
    check("timeout_fe", fe_cnt - fe0, 1);
    check("timeout_latency", fe_cyc - last_edge, 104);
    send(8'h75);
    check("timeout_clears_ext", keys, 8'h00);
    send(8'h23);
    check("d_after_timeout", keys, 8'h08);
    send(8'h1C);
    check("a_held", keys, 8'h0C);
    f = frame(8'hE0, 1'b0);
    send_range(f, 0, 6);
    @(posedge clock);
    #3 reset_n = 1'b1;
    #1 check("async_reset_keys", keys, 8'h00);
    check("async_reset_rx", rx_byte, 8'h00);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    send_range(f, 7, 10);
    repeat (150) @(negedge clock);
    check("tail_no_keys", keys, 8'h00);
    send(8'h1C);
    check("a_after_reset", keys, 8'h04);
    check("pulse_overlap", overlap, 0);
    check("pulse_width", long_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
